perf_monitor: RTL and testbench
===============================

Name: perf_monitor

Overview:
- Parametrised successor to the CPU's misc display/statistics controller.
- Generates a CPU step strobe from a runtime-selectable divider and keeps a bank of NUM_EVENTS event counters (bubbles, jumps, cycles, ...).
- Multiplexes NUM_LIVE live words plus all counters onto one registered display word.
- Adds over the previous generation: clear, freeze, saturate/wrap mode, sticky overflow flags, and a clock-enable strobe in place of a derived clock.

Parameters:
- DATA_WIDTH, 32, width of live words, counters and display output.
- NUM_LIVE, 4, number of live (uncounted) input words.
- NUM_EVENTS, 4, number of event counters.
- SEL_WIDTH, 3, width of select; must satisfy 2^SEL_WIDTH >= NUM_LIVE+NUM_EVENTS.
- FAST_DIV, 2, clocks per step strobe when frequency=0 (>=1).
- SLOW_DIV, 500000, clocks per step strobe when frequency=1 (>=1).
- MEM_SELECT, 1, select value that requests CPU halt and memory-address takeover.
- SATURATE, 0, 1 = counters stick at all-ones; 0 = counters wrap.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- frequency  in  1  0 = FAST_DIV, 1 = SLOW_DIV.
- step  out  1  one-clock-wide clock-enable strobe for the CPU.
- events  in  NUM_EVENTS  level event inputs, sampled only on step cycles.
- liveData  in  NUM_LIVE*DATA_WIDTH  packed live words; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- select  in  SEL_WIDTH  display source index.
- freeze  in  1  level; 1 = counters hold.
- clear  in  1  synchronous; 1 = zero all counters and overflow flags.
- data  out  DATA_WIDTH  registered display word.
- overflow  out  NUM_EVENTS  sticky per-counter overflow flags.
- enable  out  1  0 when select==MEM_SELECT (CPU halt), else 1.
- memoryAddressControl  out  1  1 when select==MEM_SELECT, else 0.

Behaviour:
Reset (reset=0, asynchronous)
- divCount=0, step=0, all counters=0, overflow=0, data=0, frequency shadow=0.
- enable and memoryAddressControl are combinational from select and are not affected by reset.

Divider
- Active period D = frequency ? SLOW_DIV : FAST_DIV.
- Each clock: if divCount==D-1, then step<=1 and divCount<=0; else step<=0 and divCount<=divCount+1.
- step is registered: exactly one clock wide, period D clocks.
- D=1 gives step permanently 1 after the first clock out of reset.
- frequency is registered into a shadow each clock. On any shadow/input mismatch, divCount<=0 and step<=0 that clock, and counting restarts under the new D.
- No glitch pulse may appear on a frequency change.

Counters (index k)
- Priority: clear > freeze > increment.
- clear=1: counter<=0 and overflow[k]<=0, regardless of step or freeze.
- Increment condition: step=1, freeze=0, clear=0, events[k]=1. The counter updates in the same clock step is high.
- Counter at all-ones when an increment occurs:
  - SATURATE=1: counter holds all-ones.
  - SATURATE=0: counter wraps to 0.
  - Either mode: overflow[k]<=1, held until clear or reset.
- Counters are unsigned, DATA_WIDTH bits.

Display
- Source selection:
  - select < NUM_LIVE: liveData word select.
  - NUM_LIVE <= select < NUM_LIVE+NUM_EVENTS: counter[select-NUM_LIVE].
  - Any other select value: 0.
- data is registered every clock: one-clock latency from select/liveData change.
- A counter shown on data reflects the counter value after the previous edge, so data lags the counter by one clock.

Halt
- enable = ~(select==MEM_SELECT) and memoryAddressControl = (select==MEM_SELECT), both combinational.
- step keeps toggling while halted; gating the CPU with enable is the consumer's job.

Test Plan:
1. Divider: defaults, frequency=0 after reset release → step high one clock in every 2. Switch to frequency=1 mid-period (SLOW_DIV overridden to 5) → no pulse on the switch clock, then first pulse 5 clocks later, period 5.
2. Counting and priority: events=4'b0101 held for 10 step pulses → counter0=10, counter2=10, counters 1 and 3 =0. Raise freeze for 5 step pulses → counters unchanged. Assert clear together with freeze on a step cycle → all counters 0.
3. Wrap/saturate: DATA_WIDTH=4, SATURATE=0, 17 events on counter0 → counter0=1, overflow[0]=1. Rerun with SATURATE=1 → counter0=15, overflow[0]=1. Clear → overflow 0.
4. Display mux: liveData words = 0xA0..0xA3, counter1=7. Check select=2 → data=0xA2 one clock later; select=5 → data=7; select=0 → data=0xA0.
5. Out-of-range select: NUM_LIVE=2, NUM_EVENTS=3, select=7 → data=0.
6. Halt: select=1 → enable=0, memoryAddressControl=1 immediately; select=0 → enable=1, memoryAddressControl=0.
7. Reset mid-operation: pull reset low mid-period with nonzero counters → step, data, all counters and overflow read 0 asynchronously, before the next edge. Release reset → first step exactly D clocks later.

Source files
------------

// File: rtl/perf_monitor.sv
// perf_monitor
//   Step-strobe generator, event counter bank and display multiplexer for the
//   CPU's display/statistics path.
//
// Ports
//   clock                 system clock, all state on the rising edge
//   reset                 asynchronous active-low reset
//   frequency             0 = FAST_DIV clocks per step, 1 = SLOW_DIV
//   step                  registered one-clock clock-enable strobe for the CPU
//   events                level event inputs, counted only on step cycles
//   liveData              packed live words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   select                display source index
//   freeze                1 = counters hold
//   clear                 synchronous clear of counters and overflow flags
//   data                  registered display word
//   overflow              sticky per-counter overflow flags
//   enable                0 while select == MEM_SELECT (CPU halt)
//   memoryAddressControl  1 while select == MEM_SELECT
module perf_monitor #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_LIVE   = 4,
   parameter int unsigned NUM_EVENTS = 4,
   parameter int unsigned SEL_WIDTH  = 3,
   parameter int unsigned FAST_DIV   = 2,
   parameter int unsigned SLOW_DIV   = 500000,
   parameter int unsigned MEM_SELECT = 1,
   parameter int unsigned SATURATE   = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           frequency,
   output logic                           step,
   input  logic [NUM_EVENTS-1:0]          events,
   input  logic [NUM_LIVE*DATA_WIDTH-1:0] liveData,
   input  logic [SEL_WIDTH-1:0]           select,
   input  logic                           freeze,
   input  logic                           clear,
   output logic [DATA_WIDTH-1:0]          data,
   output logic [NUM_EVENTS-1:0]          overflow,
   output logic                           enable,
   output logic                           memoryAddressControl
);

   localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
   // +1 keeps the counter at least one bit wide when both dividers are 1
   localparam int unsigned CNT_W   = $clog2(MAX_DIV + 1);

   logic [CNT_W-1:0]      divCount;
   logic [CNT_W-1:0]      divTop;
   logic                  freqShadow;
   logic [DATA_WIDTH-1:0] counters [NUM_EVENTS];
   logic [DATA_WIDTH-1:0] displayNext;
   int unsigned           selIdx;

   // ---------------------------------------------------------------- divider
   always_comb begin
      divTop = frequency ? CNT_W'(SLOW_DIV - 1) : CNT_W'(FAST_DIV - 1);
   end

   // A frequency change restarts the period and suppresses the strobe for that
   // clock, so no short pulse can be produced by the switch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         divCount   <= '0;
         step       <= 1'b0;
         freqShadow <= 1'b0;
      end else begin
         freqShadow <= frequency;
         if (frequency != freqShadow) begin
            divCount <= '0;
            step     <= 1'b0;
         end else if (divCount == divTop) begin
            divCount <= '0;
            step     <= 1'b1;
         end else begin
            divCount <= divCount + CNT_W'(1);
            step     <= 1'b0;
         end
      end
   end

   // --------------------------------------------------------------- counters
   // Priority: clear > freeze > increment.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < NUM_EVENTS; k++) counters[k] <= '0;
         overflow <= '0;
      end else if (clear) begin
         for (int unsigned k = 0; k < NUM_EVENTS; k++) counters[k] <= '0;
         overflow <= '0;
      end else if (step && !freeze) begin
         for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
            if (events[k]) begin
               if (counters[k] == '1) begin
                  overflow[k] <= 1'b1;
                  // saturating mode simply leaves the counter at all-ones
                  if (SATURATE == 0) counters[k] <= '0;
               end else begin
                  counters[k] <= counters[k] + DATA_WIDTH'(1);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- display
   always_comb begin
      displayNext = '0;
      selIdx      = 32'(select);
      for (int unsigned i = 0; i < NUM_LIVE; i++) begin
         if (selIdx == i) displayNext = liveData[i*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
         if (selIdx == NUM_LIVE + k) displayNext = counters[k];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) data <= '0;
      else        data <= displayNext;
   end

   // ------------------------------------------------------------------- halt
   always_comb begin
      memoryAddressControl = (32'(select) == MEM_SELECT);
      enable               = ~memoryAddressControl;
   end

endmodule

// File: tb/tb_perf_monitor.sv
module tb_perf_monitor;

   logic         clock = 1'b0;
   logic         reset = 1'b0;

   // main instance: defaults, SLOW_DIV shortened to 5
   logic         freq0   = 1'b0;
   logic [3:0]   events0 = '0;
   logic [127:0] live0   = '0;
   logic [2:0]   sel0    = '0;
   logic         freeze0 = 1'b0;
   logic         clear0  = 1'b0;
   logic         step0, en0, mac0;
   logic [31:0]  data0;
   logic [3:0]   ovf0;

   // narrow instances (wrap and saturate), shared inputs
   logic         freq2   = 1'b0;
   logic [2:0]   events2 = '0;
   logic [7:0]   live2   = 8'h96;
   logic [2:0]   sel2    = '0;
   logic         freeze2 = 1'b0;
   logic         clear2  = 1'b0;
   logic         step1, en1, mac1, step2, en2, mac2;
   logic [3:0]   data1, data2;
   logic [2:0]   ovf1, ovf2;

   int unsigned vectors = 0;
   int unsigned errs    = 0;

   always #5 clock = ~clock;

   perf_monitor #(.DATA_WIDTH(32), .NUM_LIVE(4), .NUM_EVENTS(4), .SEL_WIDTH(3),
                  .FAST_DIV(2), .SLOW_DIV(5), .MEM_SELECT(1), .SATURATE(0)) u0 (
      .clock(clock), .reset(reset), .frequency(freq0), .step(step0),
      .events(events0), .liveData(live0), .select(sel0), .freeze(freeze0),
      .clear(clear0), .data(data0), .overflow(ovf0), .enable(en0),
      .memoryAddressControl(mac0));

   perf_monitor #(.DATA_WIDTH(4), .NUM_LIVE(2), .NUM_EVENTS(3), .SEL_WIDTH(3),
                  .FAST_DIV(1), .SLOW_DIV(1), .MEM_SELECT(1), .SATURATE(0)) u1 (
      .clock(clock), .reset(reset), .frequency(freq2), .step(step1),
      .events(events2), .liveData(live2), .select(sel2), .freeze(freeze2),
      .clear(clear2), .data(data1), .overflow(ovf1), .enable(en1),
      .memoryAddressControl(mac1));

   perf_monitor #(.DATA_WIDTH(4), .NUM_LIVE(2), .NUM_EVENTS(3), .SEL_WIDTH(3),
                  .FAST_DIV(1), .SLOW_DIV(1), .MEM_SELECT(1), .SATURATE(1)) u2 (
      .clock(clock), .reset(reset), .frequency(freq2), .step(step2),
      .events(events2), .liveData(live2), .select(sel2), .freeze(freeze2),
      .clear(clear2), .data(data2), .overflow(ovf2), .enable(en2),
      .memoryAddressControl(mac2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // bounded wait until u0 step is seen high after an edge
   task automatic waitStep();
      int unsigned n = 0;
      while (step0 !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("step_wait", {31'b0, step0}, 32'd1);
   endtask

   // n step pulses, each consumed by the edge that ends the step cycle
   task automatic pulses(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         waitStep();
         tick();
      end
   endtask

   task automatic readCnt(input logic [2:0] s, input logic [31:0] exp, input string tag);
      sel0 = s;
      tick();
      check(tag, data0, exp);
   endtask

   initial begin
      // ---------------- reset state
      #2;
      check("rst_step", {31'b0, step0}, 32'd0);
      check("rst_data", data0, 32'd0);
      check("rst_ovf", {28'b0, ovf0}, 32'd0);
      check("rst_data_u1", {28'b0, data1}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // ---------------- divider, FAST_DIV=2
      tick(); check("div_e1", {31'b0, step0}, 32'd0);
      tick(); check("div_e2", {31'b0, step0}, 32'd1);
      tick(); check("div_e3", {31'b0, step0}, 32'd0);
      tick(); check("div_e4", {31'b0, step0}, 32'd1);
      tick(); check("div_e5", {31'b0, step0}, 32'd0);
      // switch to SLOW_DIV=5 mid-period
      freq0 = 1'b1;
      tick(); check("div_switch", {31'b0, step0}, 32'd0);
      for (int unsigned i = 0; i < 4; i++) begin
         tick(); check("div_slow_lo", {31'b0, step0}, 32'd0);
      end
      tick(); check("div_slow_hi1", {31'b0, step0}, 32'd1);
      for (int unsigned i = 0; i < 4; i++) begin
         tick(); check("div_slow_lo2", {31'b0, step0}, 32'd0);
      end
      tick(); check("div_slow_hi2", {31'b0, step0}, 32'd1);
      freq0 = 1'b0;

      // ---------------- counting
      events0 = 4'b0101;
      pulses(10);
      events0 = '0;
      readCnt(3'd4, 32'd10, "cnt0_10");
      readCnt(3'd5, 32'd0,  "cnt1_0");
      readCnt(3'd6, 32'd10, "cnt2_10");
      readCnt(3'd7, 32'd0,  "cnt3_0");
      // freeze holds
      freeze0 = 1'b1;
      events0 = 4'b1111;
      pulses(5);
      events0 = '0;
      readCnt(3'd4, 32'd10, "frz_cnt0");
      readCnt(3'd5, 32'd0,  "frz_cnt1");
      readCnt(3'd6, 32'd10, "frz_cnt2");
      // clear with freeze on a step cycle
      waitStep();
      clear0  = 1'b1;
      events0 = 4'b1111;
      tick();
      clear0  = 1'b0;
      freeze0 = 1'b0;
      events0 = '0;
      readCnt(3'd4, 32'd0, "clr_cnt0");
      readCnt(3'd6, 32'd0, "clr_cnt2");
      check("clr_ovf", {28'b0, ovf0}, 32'd0);

      // ---------------- display mux
      events0 = 4'b0010;
      pulses(7);
      events0 = '0;
      live0 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      readCnt(3'd0, 32'hA0, "mux_sel0");
      sel0 = 3'd2;
      #1;
      check("mux_latency", data0, 32'hA0);
      tick(); check("mux_sel2", data0, 32'hA2);
      readCnt(3'd5, 32'd7,  "mux_sel5");
      readCnt(3'd0, 32'hA0, "mux_sel0b");
      readCnt(3'd7, 32'd0,  "mux_sel7");

      // ---------------- halt
      sel0 = 3'd1;
      sel2 = 3'd1;
      #1;
      check("halt_en", {31'b0, en0}, 32'd0);
      check("halt_mac", {31'b0, mac0}, 32'd1);
      check("halt_en_u1", {31'b0, en1}, 32'd0);
      check("halt_mac_u2", {31'b0, mac2}, 32'd1);
      sel0 = 3'd0;
      sel2 = 3'd0;
      #1;
      check("run_en", {31'b0, en0}, 32'd1);
      check("run_mac", {31'b0, mac0}, 32'd0);
      check("run_en_u2", {31'b0, en2}, 32'd1);
      check("run_mac_u1", {31'b0, mac1}, 32'd0);

      // ---------------- wrap / saturate on 4-bit counters
      sel2 = 3'd2;
      tick();
      events2 = 3'b001;
      for (int unsigned i = 0; i < 15; i++) tick();
      check("ovf_u1_at15", {29'b0, ovf1}, 32'd0);
      check("ovf_u2_at15", {29'b0, ovf2}, 32'd0);
      tick();
      tick();
      events2 = '0;
      check("ovf_u1_wrap", {29'b0, ovf1}, 32'd1);
      check("ovf_u2_sat", {29'b0, ovf2}, 32'd1);
      tick();
      check("cnt_u1_wrap", {28'b0, data1}, 32'd1);
      check("cnt_u2_sat", {28'b0, data2}, 32'd15);

      // ---------------- out-of-range select
      sel2 = 3'd7; tick(); check("oor_sel7", {28'b0, data1}, 32'd0);
      sel2 = 3'd5; tick(); check("oor_sel5", {28'b0, data1}, 32'd0);
      sel2 = 3'd1; tick(); check("live_u1_w1", {28'b0, data1}, 32'd9);

      // ---------------- reset mid-operation
      events0 = 4'b0001;
      pulses(3);
      events0 = '0;
      readCnt(3'd4, 32'd3, "pre_rst_cnt0");
      waitStep();
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("arst_step", {31'b0, step0}, 32'd0);
      check("arst_data", data0, 32'd0);
      check("arst_ovf_u1", {29'b0, ovf1}, 32'd0);
      check("arst_ovf_u2", {29'b0, ovf2}, 32'd0);
      check("arst_data_u1", {28'b0, data1}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      check("rel_step_e1", {31'b0, step0}, 32'd0);
      check("rel_step_u1", {31'b0, step1}, 32'd1);
      tick();
      check("rel_step_e2", {31'b0, step0}, 32'd1);
      check("rel_step_u2", {31'b0, step2}, 32'd1);
      check("rel_cnt0", data0, 32'd0);

      // ---------------- overflow again, then clear
      sel2 = 3'd2;
      events2 = 3'b001;
      for (int unsigned i = 0; i < 16; i++) tick();
      events2 = '0;
      check("ovf2_u1", {29'b0, ovf1}, 32'd1);
      check("ovf2_u2", {29'b0, ovf2}, 32'd1);
      clear2 = 1'b1;
      tick();
      clear2 = 1'b0;
      check("clr_ovf_u1", {29'b0, ovf1}, 32'd0);
      check("clr_ovf_u2", {29'b0, ovf2}, 32'd0);
      tick();
      check("clr_cnt_u1", {28'b0, data1}, 32'd0);
      check("clr_cnt_u2", {28'b0, data2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
